// File: rtl/regfile_pkg.sv
// Shared types and constants for the clearable register file.
// Optional feature macro: REGFILE_CLR_BYPASS_EN (write-to-read forwarding).
package regfile_pkg;

  localparam int unsigned DefaultWidth = 8;
  localparam int unsigned DefaultAw    = 4;

  typedef enum logic [0:0] {
    StIdle,
    StSweep
  } sweep_state_e;

  // Register 0 is hardwired when zero_reg is set, so the sweep can skip it.
  function automatic int unsigned sweep_start(int unsigned zero_reg);
    return (zero_reg != 0) ? 1 : 0;
  endfunction

endpackage

// File: rtl/regfile_clr_if.sv
// Decoder/datapath-facing bus of the clearable register file.
interface regfile_clr_if
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned AW    = DefaultAw
);

  logic             we3;
  logic [AW-1:0]    wa3;
  logic [WIDTH-1:0] wd3;
  logic [AW-1:0]    ra1;
  logic [AW-1:0]    ra2;
  logic [WIDTH-1:0] rd1;
  logic [WIDTH-1:0] rd2;
  logic             clr_req;
  logic             busy;
  logic             wr_drop;

  modport master (
    output we3, wa3, wd3, ra1, ra2, clr_req,
    input  rd1, rd2, busy, wr_drop
  );

  modport slave (
    input  we3, wa3, wd3, ra1, ra2, clr_req,
    output rd1, rd2, busy, wr_drop
  );

endinterface

// File: rtl/regfile_sweep.sv
// Sweep-clear controller: FSM, clear pointer, busy and dropped-write flags.
module regfile_sweep
  import regfile_pkg::*;
#(
  parameter int unsigned AW       = DefaultAw,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr_req,
  input  logic          we3,
  input  logic [AW-1:0] wa3,
  output logic          busy,
  output logic          wr_drop,
  output logic          sweep_we,
  output logic [AW-1:0] sweep_addr
);

  localparam logic [AW-1:0] Start = AW'(sweep_start(ZERO_REG));
  localparam logic [AW-1:0] Last  = {AW{1'b1}};

  sweep_state_e  state_q;
  logic [AW-1:0] ptr_q;
  logic          busy_q;
  logic          drop_q;
  logic          zero_target;

  // Writes to a hardwired register 0 vanish without being reported as drops.
  assign zero_target = (ZERO_REG != 0) && (wa3 == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      busy_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      drop_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (clr_req) begin
            state_q <= StSweep;
            ptr_q   <= Start;
            busy_q  <= 1'b1;
          end
        end
        StSweep: begin
          drop_q <= we3 && !zero_target;
          ptr_q  <= ptr_q + AW'(1);
          if (ptr_q == Last) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign wr_drop    = drop_q;
  assign sweep_we   = busy_q;
  assign sweep_addr = ptr_q;

endmodule

// File: rtl/regfile_clr.sv
// Two-read/one-write register file with sweep clear and async reset.
// Optional feature macro: REGFILE_CLR_BYPASS_EN (write-to-read forwarding).
module regfile_clr
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH    = DefaultWidth,
  parameter int unsigned AW       = DefaultAw,
  parameter int unsigned ZERO_REG = 1
) (
  input logic          clk,
  input logic          reset,
  regfile_clr_if.slave bus
);

  localparam int unsigned DEPTH = 2 ** AW;

  logic [WIDTH-1:0] mem [DEPTH];
  logic             busy;
  logic             sweep_we;
  logic [AW-1:0]    sweep_addr;
  logic             user_we;

  regfile_sweep #(
    .AW       (AW),
    .ZERO_REG (ZERO_REG)
  ) u_sweep (
    .clk        (clk),
    .reset      (reset),
    .clr_req    (bus.clr_req),
    .we3        (bus.we3),
    .wa3        (bus.wa3),
    .busy       (busy),
    .wr_drop    (bus.wr_drop),
    .sweep_we   (sweep_we),
    .sweep_addr (sweep_addr)
  );

  assign bus.busy = busy;
  assign user_we  = bus.we3 && !busy && !((ZERO_REG != 0) && (bus.wa3 == '0));

  // Sweep owns the write port while busy; user writes are dropped then.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (sweep_we) begin
      mem[sweep_addr] <= '0;
    end else if (user_we) begin
      mem[bus.wa3] <= bus.wd3;
    end
  end

  always_comb begin
    bus.rd1 = mem[bus.ra1];
    bus.rd2 = mem[bus.ra2];
    if ((ZERO_REG != 0) && (bus.ra1 == '0)) bus.rd1 = '0;
    if ((ZERO_REG != 0) && (bus.ra2 == '0)) bus.rd2 = '0;
`ifdef REGFILE_CLR_BYPASS_EN
    if (user_we && (bus.wa3 == bus.ra1)) bus.rd1 = bus.wd3;
    if (user_we && (bus.wa3 == bus.ra2)) bus.rd2 = bus.wd3;
`endif
  end

endmodule

// File: tb/tb_regfile_clr.sv
// Bench for regfile_clr: vector table, directed sweep cases, random run vs model.
module tb_regfile_clr;

  logic clk = 1'b0;
  logic reset;
  always #20 clk = ~clk;

  regfile_clr_if #(.WIDTH(8), .AW(4))  bus ();
  regfile_clr_if #(.WIDTH(16), .AW(3)) bus0 ();

  regfile_clr #(.WIDTH(8), .AW(4), .ZERO_REG(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  regfile_clr #(.WIDTH(16), .AW(3), .ZERO_REG(0)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: contents plus a queue of addresses still to be cleared.
  logic [7:0] m [16];
  int         pend [$];
  bit         drop_m;

  typedef struct {
    logic       we;
    logic [3:0] wa;
    logic [7:0] wd;
    logic [3:0] ra;
    logic [7:0] exp;
  } vec_t;

  vec_t vt [8];

  task automatic chk(string name, logic [31:0] got, logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  function automatic logic [7:0] exp_rd(logic [3:0] ra);
    if (ra == 4'd0) return 8'h00;
`ifdef REGFILE_CLR_BYPASS_EN
    if (bus.we3 && pend.size() == 0 && bus.wa3 == ra) return bus.wd3;
`endif
    return m[ra];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m[i] = 8'h00;
    pend.delete();
    drop_m = 1'b0;
  endtask

  task automatic model_edge();
    bit busy_m;
    busy_m = (pend.size() != 0);
    drop_m = busy_m && bus.we3 && (bus.wa3 != 4'd0);
    if (busy_m) begin
      m[pend.pop_front()] = 8'h00;
    end else begin
      if (bus.we3 && bus.wa3 != 4'd0) m[bus.wa3] = bus.wd3;
      if (bus.clr_req) for (int i = 1; i < 16; i++) pend.push_back(i);
    end
  endtask

  // Inputs are set in the low phase; outputs checked then the edge is applied.
  task automatic tick();
    #1;
    chk("rd1", bus.rd1, exp_rd(bus.ra1));
    chk("rd2", bus.rd2, exp_rd(bus.ra2));
    chk("busy", bus.busy, pend.size() != 0);
    chk("wr_drop", bus.wr_drop, drop_m);
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic drain(output int n);
    n = 0;
    while (bus.busy === 1'b1 && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) begin
      total++;
      bad++;
      $display("FAIL busy_timeout got=busy want=idle");
    end
  endtask

  task automatic wr(logic [3:0] a, logic [7:0] d);
    bus.we3 = 1'b1;
    bus.wa3 = a;
    bus.wd3 = d;
    tick();
    bus.we3 = 1'b0;
  endtask

  int n;

  initial begin
    reset = 1'b1;
    bus.we3 = 0; bus.wa3 = 0; bus.wd3 = 0; bus.ra1 = 0; bus.ra2 = 0; bus.clr_req = 0;
    bus0.we3 = 0; bus0.wa3 = 0; bus0.wd3 = 0; bus0.ra1 = 0; bus0.ra2 = 0; bus0.clr_req = 0;
    model_reset();
    vt[0] = '{1'b1, 4'd3,  8'hA5, 4'd4,  8'h00};
    vt[1] = '{1'b0, 4'd0,  8'h00, 4'd3,  8'hA5};
    vt[2] = '{1'b1, 4'd0,  8'hFF, 4'd3,  8'hA5};
    vt[3] = '{1'b0, 4'd0,  8'h00, 4'd0,  8'h00};
    vt[4] = '{1'b1, 4'd15, 8'h5A, 4'd3,  8'hA5};
    vt[5] = '{1'b0, 4'd0,  8'h00, 4'd15, 8'h5A};
    vt[6] = '{1'b1, 4'd3,  8'h00, 4'd15, 8'h5A};
    vt[7] = '{1'b0, 4'd0,  8'h00, 4'd3,  8'h00};
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset_rd1", bus.rd1, 0);
    chk("reset_busy", bus.busy, 0);
    chk("reset_drop", bus.wr_drop, 0);

    for (int i = 0; i < 8; i++) begin
      bus.we3 = vt[i].we; bus.wa3 = vt[i].wa; bus.wd3 = vt[i].wd;
      bus.ra1 = vt[i].ra; bus.ra2 = vt[i].ra;
      #1;
      chk("vec_rd1", bus.rd1, vt[i].exp);
      tick();
    end
    bus.we3 = 1'b0;

    // Fill, sweep, inspect a partially cleared bank.
    for (int i = 1; i < 16; i++) wr(4'(i), 8'(8'h10 + i));
    bus.clr_req = 1'b1; tick(); bus.clr_req = 1'b0;
    repeat (5) tick();
    for (int i = 1; i < 16; i++) begin
      bus.ra1 = 4'(i);
      #1;
      chk("mid_sweep", bus.rd1, (i <= 5) ? 8'h00 : 8'(8'h10 + i));
    end
    drain(n);
    chk("busy_len", n + 5, 15);
    for (int i = 0; i < 16; i++) begin
      bus.ra1 = 4'(i);
      #1;
      chk("post_sweep", bus.rd1, 0);
    end

    // Write dropped after the pointer has passed its target.
    wr(4'd5, 8'h55);
    bus.clr_req = 1'b1; tick(); bus.clr_req = 1'b0;
    repeat (9) tick();
    wr(4'd5, 8'h7E);
    #1;
    chk("drop_pulse", bus.wr_drop, 1);
    drain(n);
    bus.ra1 = 4'd5;
    #1;
    chk("drop_r5", bus.rd1, 0);

    // Write concurrent with the clear request.
    bus.we3 = 1'b1; bus.wa3 = 4'd5; bus.wd3 = 8'h55; bus.clr_req = 1'b1;
    tick();
    bus.we3 = 1'b0; bus.clr_req = 1'b0;
    drain(n);
    chk("collide_len", n, 15);
    #1;
    chk("collide_r5", bus.rd1, 0);

    // Repeated requests while sweeping neither restart nor extend.
    bus.clr_req = 1'b1; tick();
    drain(n);
    bus.clr_req = 1'b0;
    chk("reclr_len", n, 15);

    // Forwarding, idle then busy.
    wr(4'd7, 8'h77);
    bus.we3 = 1'b1; bus.wa3 = 4'd7; bus.wd3 = 8'h3C; bus.ra2 = 4'd7;
    #1;
`ifdef REGFILE_CLR_BYPASS_EN
    chk("bypass", bus.rd2, 8'h3C);
`else
    chk("no_bypass", bus.rd2, 8'h77);
`endif
    tick();
    bus.we3 = 1'b0;
    bus.clr_req = 1'b1; tick(); bus.clr_req = 1'b0;
    bus.we3 = 1'b1; bus.wa3 = 4'd7; bus.wd3 = 8'h99;
    #1;
    chk("busy_no_fwd", bus.rd2, 8'h3C);
    tick();
    bus.we3 = 1'b1; bus.wa3 = 4'd9;
    tick();
    bus.we3 = 1'b0;

    // Reset in the middle of a sweep with a drop pending.
    #5;
    reset = 1'b1;
    #1;
    for (int i = 0; i < 16; i++) begin
      bus.ra1 = 4'(i); bus.ra2 = 4'(15 - i);
      #1;
      chk("rst_rd1", bus.rd1, 0);
      chk("rst_rd2", bus.rd2, 0);
    end
    chk("rst_busy", bus.busy, 0);
    chk("rst_drop", bus.wr_drop, 0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;

    for (int k = 0; k < 400; k++) begin
      bus.we3 = 1'($urandom_range(0, 1));
      bus.wa3 = 4'($urandom_range(0, 15));
      bus.wd3 = 8'($urandom_range(0, 255));
      bus.ra1 = 4'($urandom_range(0, 15));
      bus.ra2 = 4'($urandom_range(0, 15));
      bus.clr_req = ($urandom_range(0, 19) == 0);
      tick();
    end
    bus.we3 = 1'b0; bus.clr_req = 1'b0;
    drain(n);

    // Ordinary register 0, eight-entry bank.
    bus0.we3 = 1'b1; bus0.wa3 = 3'd0; bus0.wd3 = 16'hBEEF;
    tick();
    bus0.wa3 = 3'd7; bus0.wd3 = 16'h1234;
    tick();
    bus0.we3 = 1'b0; bus0.ra1 = 3'd0; bus0.ra2 = 3'd7;
    #1;
    chk("z0_r0", bus0.rd1, 16'hBEEF);
    chk("z0_r7", bus0.rd2, 16'h1234);
    bus0.clr_req = 1'b1; tick(); bus0.clr_req = 1'b0;
    n = 0;
    while (bus0.busy === 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk("z0_len", n, 8);
    #1;
    chk("z0_r0_clr", bus0.rd1, 0);
    chk("z0_r7_clr", bus0.rd2, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
